cic_decim_out_stage: RTL and testbench

// - Output stage directly downstream of the comb/integrator filter block. Consumes its valid-qualified

---
 rtl/cic_decim_out_stage.sv | 76 +++++++
 tb/tb_cic_decim_out_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cic_decim_out_stage.sv
// cic_decim_out_stage: decimate, round, saturate and FIFO-buffer a CIC sample stream
module cic_decim_out_stage #(
  parameter int NBW_IN     = 8,
  parameter int NBW_OUT    = 6,
  parameter int DEC_FACTOR = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             rst_async_n,
  input  logic [NBW_IN-1:0]                i_data,
  input  logic                             i_valid,
  input  logic                             i_phase_clr,
  input  logic                             i_ovf_clr,
  input  logic                             i_ready,
  output logic [NBW_OUT-1:0]               o_data,
  output logic                             o_valid,
  output logic                             o_sat,
  output logic                             o_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_level
);
  localparam int CW = DEC_FACTOR > 1 ? $clog2(DEC_FACTOR) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam logic signed [NBW_IN:0] RND  = (NBW_IN+1)'((2**SHIFT)/2);
  localparam logic signed [NBW_IN:0] MAXV = (NBW_IN+1)'(2**(NBW_OUT-1)-1);
  localparam logic signed [NBW_IN:0] MINV = (NBW_IN+1)'(-(2**(NBW_OUT-1)));
  logic [CW-1:0] cnt;
  logic st_valid, st_sat;
  logic [NBW_OUT-1:0] st_data;
  logic [NBW_OUT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic last, keep, wr, pop, full, wr_ok, drop, sat;
  logic signed [NBW_IN:0] rnd, y, yc;
  always_comb begin
    last  = cnt == CW'(DEC_FACTOR-1);
    keep  = i_valid & ~i_phase_clr & last;
    rnd   = $signed({i_data[NBW_IN-1], i_data}) + RND;
    y     = rnd >>> SHIFT;
    sat   = y > MAXV || y < MINV;
    yc    = y > MAXV ? MAXV : y < MINV ? MINV : y;
    wr    = st_valid & ~i_phase_clr;
    pop   = o_valid & i_ready;
    full  = o_level == LW'(FIFO_DEPTH);
    wr_ok = wr & (~full | pop);
    drop  = wr & full & ~pop;
  end
  assign o_valid = o_level != '0;
  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clock or negedge rst_async_n)
    if (!rst_async_n) begin
      cnt        <= '0;
      st_valid   <= 1'b0;
      st_sat     <= 1'b0;
      st_data    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      cnt      <= i_phase_clr ? '0 : i_valid ? (last ? '0 : cnt + 1'b1) : cnt;
      st_valid <= keep;
      if (keep) begin
        st_data <= yc[NBW_OUT-1:0];
        st_sat  <= sat;
      end
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_level    <= o_level + LW'(wr_ok) - LW'(pop);
      o_sat      <= wr_ok & st_sat;
      o_overflow <= drop | (o_overflow & ~i_ovf_clr);
    end
  always_ff @(posedge clock)
    if (wr_ok) mem[wr_ptr] <= st_data;
endmodule

// File: tb/tb_cic_decim_out_stage.sv
// tb_cic_decim_out_stage: directed checks of decimation, rounding, saturation and FIFO handshake
module tb_cic_decim_out_stage;
  logic clock = 1'b0;
  logic rst_async_n = 1'b0;
  logic [7:0] i_data = '0;
  logic i_valid = 1'b0, i_phase_clr = 1'b0, i_ovf_clr = 1'b0, i_ready = 1'b0;
  logic [5:0] o_data;
  logic o_valid, o_sat, o_overflow;
  logic [2:0] o_level;
  int checks = 0, errors = 0;
  int rs_in [4]  = '{127, -128, -7, 6};
  int rs_out [4] = '{31, -32, -2, 2};
  int rs_sat [4] = '{1, 0, 0, 0};
  cic_decim_out_stage dut (
    .clock(clock), .rst_async_n(rst_async_n), .i_data(i_data), .i_valid(i_valid),
    .i_phase_clr(i_phase_clr), .i_ovf_clr(i_ovf_clr), .i_ready(i_ready), .o_data(o_data),
    .o_valid(o_valid), .o_sat(o_sat), .o_overflow(o_overflow), .o_level(o_level)
  );
  always #5 clock = ~clock;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic feed(input int v);
    i_data = 8'(v);
    i_valid = 1'b1;
    step;
    i_valid = 1'b0;
  endtask
  task automatic feed_kept(input int v);
    for (int i = 0; i < 3; i++) feed(0);
    feed(v);
  endtask
  initial begin
    step;
    step;
    chk("rst_data", $signed(o_data), 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_level", o_level, 0);
    rst_async_n = 1'b1;
    step;
    i_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      i_data = 8'(k);
      i_valid = k < 16;
      step;
      chk("dec_valid", o_valid, (k >= 4 && k % 4 == 0) ? 1 : 0);
      if (k >= 4 && k % 4 == 0) chk("dec_data", $signed(o_data), k / 4);
    end
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      feed_kept(rs_in[i]);
      step;
      chk("rs_valid", o_valid, 1);
      chk("rs_data", $signed(o_data), rs_out[i]);
      chk("rs_sat", o_sat, rs_sat[i]);
    end
    step;
    i_ready = 1'b0;
    for (int i = 1; i <= 6; i++) feed_kept(4 * i);
    step;
    step;
    chk("bp_level", o_level, 4);
    chk("bp_ovf", o_overflow, 1);
    chk("bp_head", $signed(o_data), 1);
    step;
    chk("bp_hold", $signed(o_data), 1);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", $signed(o_data), i + 1);
      step;
    end
    chk("bp_empty", o_level, 0);
    chk("bp_ovf_sticky", o_overflow, 1);
    i_ovf_clr = 1'b1;
    step;
    i_ovf_clr = 1'b0;
    chk("bp_ovf_clr", o_overflow, 0);
    feed(1);
    feed(2);
    i_phase_clr = 1'b1;
    feed(100);
    i_phase_clr = 1'b0;
    for (int v = 40; v < 44; v++) begin
      feed(v);
      chk("pc_idle", o_valid, 0);
    end
    step;
    chk("pc_valid", o_valid, 1);
    chk("pc_data", $signed(o_data), 11);
    step;
    chk("pc_pop", o_level, 0);
    i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed_kept(4 * i);
    step;
    chk("fp_full", o_level, 4);
    feed_kept(20);
    i_ready = 1'b1;
    step;
    chk("fp_level", o_level, 4);
    chk("fp_ovf", o_overflow, 0);
    chk("fp_head", $signed(o_data), 2);
    step;
    i_ready = 1'b0;
    chk("fp_level3", o_level, 3);
    #1;
    rst_async_n = 1'b0;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_level", o_level, 0);
    chk("ar_data", $signed(o_data), 0);
    step;
    rst_async_n = 1'b1;
    step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
